// File: rtl/buf_proto_pkg.sv
// Host link protocol constants shared by the buffer loader and the command-buffer executor.
// Covers opcodes, response and error codes, loader state encoding and the 40-bit command word size.
package buf_proto_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_START    = 8'h03;
  localparam logic [7:0] OP_ABORT    = 8'h04;

  localparam logic [7:0] RESP_OK_BASE = 8'h80;
  localparam logic [7:0] RESP_TIMEOUT = 8'hFE;
  localparam logic [7:0] RESP_BAD_OP  = 8'hFF;

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_BAD_OP  = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h03;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_COUNT   = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  // Command word: 40 bits, transferred as 5 bytes MSB first.
  localparam int CMD_WORD_W     = 40;
  localparam int CMD_WORD_BYTES = 5;

  function automatic logic [7:0] resp_ok(input logic [7:0] op);
    return RESP_OK_BASE | op;
  endfunction

endpackage

// File: rtl/buf_loader.sv
// Host byte-stream front end: decodes framed packets into buffer writes, start/abort pulses
// and one response byte per packet, with an inter-byte timeout that drops stalled packets.
//
// state     | meaning
// S_IDLE    | waiting for an opcode byte
// S_ADDR_HI | collecting address MSB (SET_ADDR / START)
// S_ADDR_LO | collecting address LSB, then act
// S_COUNT   | collecting WRITE word count (0 = 256)
// S_DATA    | collecting 5-byte words, write each on its last byte
// S_RESP    | holding the response byte until out_ready
module buf_loader
  import buf_proto_pkg::*;
#(
  parameter int BUFFER_ADDR_LEN = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BUFFER_ADDR_LEN-1:0] ext_buffer_addr,
  output logic [CMD_WORD_W-1:0]      ext_buffer_data,
  output logic                       ext_buffer_wr,
  output logic                       start,
  output logic [BUFFER_ADDR_LEN-1:0] start_addr,
  output logic                       abort,
  output logic [7:0]                 last_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter loaded on every accepted byte; terminal count 0 lands on the
  // TIMEOUT_CYCLES-th idle cycle, so the response appears exactly that many edges later.
  localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [2:0]    LAST_IDX = 3'(CMD_WORD_BYTES - 1);
  localparam int            SR_W     = 8 * (CMD_WORD_BYTES - 1);

  logic [2:0]                 state;
  logic [7:0]                 opcode;
  logic [7:0]                 addr_hi;
  logic [BUFFER_ADDR_LEN-1:0] wr_ptr;
  logic [2:0]                 byte_idx;
  logic [8:0]                 words_left;
  logic [SR_W-1:0]            word_sr;
  logic [TW-1:0]              tmr;

  logic                       accept;
  logic                       in_pkt;
  logic                       timeout_fire;
  logic [BUFFER_ADDR_LEN-1:0] addr_full;

  assign accept       = in_valid && in_ready;
  assign in_pkt       = (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                        (state == S_COUNT)   || (state == S_DATA);
  assign timeout_fire = (TIMEOUT_CYCLES != 0) && in_pkt && (tmr == '0);
  assign addr_full    = BUFFER_ADDR_LEN'({addr_hi, in_data});

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      opcode          <= 8'h00;
      addr_hi         <= 8'h00;
      wr_ptr          <= '0;
      byte_idx        <= 3'd0;
      words_left      <= 9'd0;
      word_sr         <= '0;
      tmr             <= '0;
      in_ready        <= 1'b0;
      out_data        <= 8'h00;
      out_valid       <= 1'b0;
      ext_buffer_addr <= '0;
      ext_buffer_data <= '0;
      ext_buffer_wr   <= 1'b0;
      start           <= 1'b0;
      start_addr      <= '0;
      abort           <= 1'b0;
      last_error      <= ERR_NONE;
    end else begin
      ext_buffer_wr <= 1'b0;
      start         <= 1'b0;
      abort         <= 1'b0;
      if (state != S_RESP) in_ready <= 1'b1;

      if (accept) tmr <= TMR_LOAD;
      else if (in_pkt && tmr != '0) tmr <= tmr - TW'(1);

      // A byte arriving in the firing cycle is swallowed along with the partial packet.
      if (timeout_fire) begin
        state      <= S_RESP;
        out_data   <= RESP_TIMEOUT;
        out_valid  <= 1'b1;
        in_ready   <= 1'b0;
        last_error <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              opcode <= in_data;
              case (in_data)
                OP_SET_ADDR, OP_START: state <= S_ADDR_HI;
                OP_WRITE:              state <= S_COUNT;
                OP_ABORT: begin
                  abort      <= 1'b1;
                  state      <= S_RESP;
                  out_data   <= resp_ok(in_data);
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b0;
                  last_error <= ERR_NONE;
                end
                default: begin
                  state      <= S_RESP;
                  out_data   <= RESP_BAD_OP;
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b0;
                  last_error <= ERR_BAD_OP;
                end
              endcase
            end
          end
          S_ADDR_HI: begin
            if (accept) begin
              addr_hi <= in_data;
              state   <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            if (accept) begin
              if (opcode == OP_SET_ADDR) begin
                wr_ptr <= addr_full;
              end else begin
                start      <= 1'b1;
                start_addr <= addr_full;
              end
              state      <= S_RESP;
              out_data   <= resp_ok(opcode);
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              last_error <= ERR_NONE;
            end
          end
          S_COUNT: begin
            if (accept) begin
              words_left <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
              byte_idx   <= 3'd0;
              state      <= S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              if (byte_idx == LAST_IDX) begin
                ext_buffer_addr <= wr_ptr;
                ext_buffer_data <= {word_sr, in_data};
                ext_buffer_wr   <= 1'b1;
                wr_ptr          <= wr_ptr + BUFFER_ADDR_LEN'(1);
                byte_idx        <= 3'd0;
                words_left      <= words_left - 9'd1;
                if (words_left == 9'd1) begin
                  state      <= S_RESP;
                  out_data   <= resp_ok(opcode);
                  out_valid  <= 1'b1;
                  in_ready   <= 1'b0;
                  last_error <= ERR_NONE;
                end
              end else begin
                word_sr  <= {word_sr[SR_W-9:0], in_data};
                byte_idx <= byte_idx + 3'd1;
              end
            end
          end
          S_RESP: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buf_loader.sv
// Directed bench for buf_loader: packet decode, buffer writes, pulses, errors and timeout.
module tb_buf_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ext_buffer_addr;
  logic [39:0] ext_buffer_data;
  logic        ext_buffer_wr;
  logic        start;
  logic [15:0] start_addr;
  logic        abort;
  logic [7:0]  last_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_addr_q[$];
  logic [39:0] wr_data_q[$];
  bit          wr_ov_q[$];
  int          n_start, n_start_ov, n_abort, n_abort_ov, n_double;
  logic [15:0] pulse_start_addr;
  logic        prev_wr, prev_start, prev_abort;

  buf_loader #(.BUFFER_ADDR_LEN(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ext_buffer_addr(ext_buffer_addr), .ext_buffer_data(ext_buffer_data),
    .ext_buffer_wr(ext_buffer_wr), .start(start), .start_addr(start_addr),
    .abort(abort), .last_error(last_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ext_buffer_wr) begin
      wr_addr_q.push_back(ext_buffer_addr);
      wr_data_q.push_back(ext_buffer_data);
      wr_ov_q.push_back(out_valid);
    end
    if (start) begin
      n_start++;
      pulse_start_addr = start_addr;
      if (out_valid) n_start_ov++;
    end
    if (abort) begin
      n_abort++;
      if (out_valid) n_abort_ov++;
    end
    if ((ext_buffer_wr && prev_wr) || (start && prev_start) || (abort && prev_abort)) n_double++;
    prev_wr    = ext_buffer_wr;
    prev_start = start;
    prev_abort = abort;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'(1));
    @(posedge clk);
  endtask

  task automatic end_pkt();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (!out_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check(tag, 64'(out_data), 64'(exp));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_ov_q.delete();
    n_start = 0; n_start_ov = 0; n_abort = 0; n_abort_ov = 0;
  endtask

  function automatic logic [7:0] mk(input int i, input int j);
    return 8'((i * 7 + j * 3 + 1) & 255);
  endfunction

  initial begin
    logic [39:0] w;
    longint      t0, t1;
    int          ov_sum, i_hit, nw;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    n_double = 0; prev_wr = 0; prev_start = 0; prev_abort = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_in_ready",   64'(in_ready), 64'(0));
    check("rst_out_valid",  64'(out_valid), 64'(0));
    check("rst_out_data",   64'(out_data), 64'(0));
    check("rst_outs", 64'({ext_buffer_wr, start, abort, ext_buffer_addr, start_addr}), 64'(0));
    check("rst_wr_data",    64'(ext_buffer_data), 64'(0));
    check("rst_last_error", 64'(last_error), 64'(0));
    rst = 1'b0;
    #1 check("in_ready_after_rst", 64'(in_ready), 64'(0));
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));

    // SET_ADDR 0x1234 then WRITE two words
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); end_pkt();
    get_resp("resp_set_addr", 8'h81);
    foreach (wr_addr_q[k]) ; // keep queue untouched
    send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    end_pkt();
    get_resp("resp_write", 8'h82);
    check("w1_count", 64'(wr_addr_q.size()), 64'(2));
    if (wr_addr_q.size() == 2) begin
      check("w1_addr0", 64'(wr_addr_q[0]), 64'h1234);
      check("w1_data0", 64'(wr_data_q[0]), 64'h40_0000_0005);
      check("w1_addr1", 64'(wr_addr_q[1]), 64'h1235);
      check("w1_data1", 64'(wr_data_q[1]), 64'h81_0000_0001);
      check("w1_ov_seq", 64'({wr_ov_q[0], wr_ov_q[1]}), 64'(2'b01));
    end
    check("w1_last_error", 64'(last_error), 64'(0));

    // Address wrap
    clear_mon();
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); end_pkt();
    get_resp("resp_set_ffff", 8'h81);
    send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
    end_pkt();
    get_resp("resp_write_wrap", 8'h82);
    check("wrap_count", 64'(wr_addr_q.size()), 64'(2));
    if (wr_addr_q.size() == 2) begin
      check("wrap_addr0", 64'(wr_addr_q[0]), 64'hFFFF);
      check("wrap_addr1", 64'(wr_addr_q[1]), 64'h0000);
      check("wrap_data1", 64'(wr_data_q[1]), 64'hAA_BBCC_DDEE);
    end

    // WRITE N=0 -> 256 words at one byte per cycle, wr_ptr continues at 0x0001
    clear_mon();
    send_byte(8'h02); send_byte(8'h00);
    t0 = 0; t1 = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 5; j++) begin
        send_byte(mk(i, j));
        if (i == 0 && j == 0) t0 = longint'($time);
      end
    end
    t1 = longint'($time);
    end_pkt();
    get_resp("resp_write_256", 8'h82);
    check("n256_count", 64'(wr_addr_q.size()), 64'(256));
    check("n256_rate", 64'((t1 - t0) / 10), 64'(1279));
    if (wr_addr_q.size() == 256) begin
      w = {mk(0, 0), mk(0, 1), mk(0, 2), mk(0, 3), mk(0, 4)};
      check("n256_addr_first", 64'(wr_addr_q[0]), 64'h0001);
      check("n256_data_first", 64'(wr_data_q[0]), 64'(w));
      w = {mk(255, 0), mk(255, 1), mk(255, 2), mk(255, 3), mk(255, 4)};
      check("n256_addr_last", 64'(wr_addr_q[255]), 64'h0100);
      check("n256_data_last", 64'(wr_data_q[255]), 64'(w));
      ov_sum = 0;
      foreach (wr_ov_q[k]) ov_sum += int'(wr_ov_q[k]);
      check("n256_ov_last", 64'({ov_sum[7:0], 7'd0, wr_ov_q[255]}), 64'(16'h0101));
    end

    // START and ABORT
    clear_mon();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); end_pkt();
    get_resp("resp_start", 8'h83);
    check("start_pulses", 64'(n_start), 64'(1));
    check("start_with_resp", 64'(n_start_ov), 64'(1));
    check("start_addr_pulse", 64'(pulse_start_addr), 64'h0010);
    check("start_addr_hold", 64'(start_addr), 64'h0010);
    send_byte(8'h04); end_pkt();
    get_resp("resp_abort", 8'h84);
    check("abort_pulses", 64'(n_abort), 64'(1));
    check("abort_with_resp", 64'(n_abort_ov), 64'(1));

    // Unknown opcode, then recovery
    clear_mon();
    send_byte(8'h55); end_pkt();
    get_resp("resp_bad_op", 8'hFF);
    check("bad_op_error", 64'(last_error), 64'h01);
    check("bad_op_no_strobes", 64'(wr_addr_q.size() + n_start + n_abort), 64'(0));
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); end_pkt();
    get_resp("resp_set_after_err", 8'h81);
    check("err_cleared", 64'(last_error), 64'h00);

    // Timeout: WRITE N=1 with only 3 data bytes
    clear_mon();
    send_byte(8'h02); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    i_hit = 0;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
      end else begin
        @(posedge clk);
      end
      #1;
      if (out_valid) begin
        i_hit = i;
        break;
      end
    end
    check("timeout_cycle", 64'(i_hit), 64'(100));
    check("timeout_resp", 64'(out_data), 64'hFE);
    check("timeout_error", 64'(last_error), 64'h03);
    check("timeout_no_write", 64'(wr_addr_q.size()), 64'(0));
    repeat (20) @(negedge clk);
    check("timeout_hold", 64'({out_valid, in_ready}), 64'(2'b10));
    get_resp("timeout_resp_consumed", 8'hFE);

    // Reset mid-packet drops it; wr_ptr returns to 0
    clear_mon();
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_quiet", 64'({out_valid, last_error}), 64'(0));
    send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    end_pkt();
    get_resp("resp_after_rst", 8'h82);
    nw = wr_addr_q.size();
    check("midrst_count", 64'(nw), 64'(1));
    if (nw == 1) begin
      check("midrst_addr", 64'(wr_addr_q[0]), 64'h0000);
      check("midrst_data", 64'(wr_data_q[0]), 64'h11_2233_4455);
    end
    check("single_cycle_pulses", 64'(n_double), 64'(0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buf_loader.md
# buf_loader

Host-side front end for the command-buffer executor: accepts a framed byte stream (UART or USB bridge, valid/ready), assembles 40-bit command words and writes them into the executor's buffer through its write port. It also forwards START and ABORT requests and returns one response byte per packet, so the host can pace itself. It sits between the host link and the executor's `ext_buffer_*`, `start`, `start_addr` and `abort` inputs.

## Interface
- `BUFFER_ADDR_LEN`, 16: address width of the buffer write port.
- `TIMEOUT_CYCLES`, 1000000: maximum number of idle cycles allowed between bytes inside a packet. A value of 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the loader accepts the byte this cycle. A byte transfers when `in_valid && in_ready`.
- `out_data`  out  8  response byte.
- `out_valid`  out  1  the response byte is pending.
- `out_ready`  in  1  the host consumes the response this cycle.
- `ext_buffer_addr`  out  16  buffer write address.
- `ext_buffer_data`  out  40  buffer write data.
- `ext_buffer_wr`  out  1  one-cycle write strobe.
- `start`  out  1  one-cycle start pulse to the executor.
- `start_addr`  out  16  start PC. Valid while `start` is high, and holds its value afterwards.
- `abort`  out  1  one-cycle abort pulse.
- `last_error`  out  8  sticky code of the last error. It is cleared by reset and by any good packet.

## Operation
- Each packet is an opcode byte followed by a payload. All multi-byte fields are sent MSB first.
- `0x01` SET_ADDR: 2 address bytes. Loads `wr_ptr`.
- `0x02` WRITE: 1 count byte N, where N=0 means 256 words. Then N×5 data bytes follow.
  - Each 5-byte group is written at `wr_ptr`.
  - `wr_ptr` then increments modulo 2^BUFFER_ADDR_LEN, so `0xFFFF` wraps to `0x0000`.
- `0x03` START: 2 address bytes, then `start`=1 with `start_addr`=address.
- `0x04` ABORT: no payload. Issues `abort`=1.
- Response after a completed packet: `0x80|opcode`.
- Unknown opcode:
  - The byte is consumed.
  - Response `0xFF`, `last_error`=`0x01`.
- Inter-byte timeout:
  - Condition: inside a packet (any state other than S_IDLE or S_RESP), the gap since the last accepted byte reaches TIMEOUT_CYCLES.
  - The partial packet is dropped. Words already written stay in the buffer.
  - Response `0xFE`, `last_error`=`0x03`.
- States:
  - S_IDLE: waits for the opcode byte and dispatches on it.
  - S_ADDR_HI and S_ADDR_LO: collect the address, used by SET_ADDR and START.
  - S_COUNT: collects the WRITE count.
  - S_DATA: a byte index 0..4 and a remaining-word counter, 9 bits, decremented per word.
  - S_RESP: holds the response.
- Transitions:
  - Packet complete or error → S_RESP.
  - S_RESP → S_IDLE on `out_ready`.
- The loader has no knowledge of executor state. A START sent while the executor is running is ignored by the executor; the host must ABORT first.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `ext_buffer_wr`=0, `ext_buffer_addr`=0, `ext_buffer_data`=0, `start`=0, `start_addr`=0, `abort`=0, `last_error`=0, `wr_ptr`=0, state S_IDLE.
- `in_ready` is 1 in every state except S_RESP. It is 0 during reset and in the first cycle after reset.
- All strobes and data outputs are registered.
- Word write:
  - `ext_buffer_wr` pulses for exactly one cycle, in the cycle after the 5th byte of the word is accepted.
  - `ext_buffer_addr` and `ext_buffer_data` are stable in that cycle.
  - Sustained throughput is one byte per cycle.
- START and ABORT: the pulse appears in the cycle after the final byte, in the same cycle that `out_valid` rises.
- For the last WRITE word, `ext_buffer_wr` and `out_valid` rise in the same cycle.
- `out_valid` holds until `out_ready`. Back-to-back packets therefore stall by at least one cycle.
- Timeout counter:
  - Cleared on every accepted byte.
  - Counts only in packet states.
  - Firing takes effect on the cycle the count equals TIMEOUT_CYCLES.
- Reset takes priority over everything. Reset in the middle of a packet drops the packet with no pulses and no response.

## Structure
- Package `buf_proto_pkg`:
  - opcode constants (`OP_SET_ADDR`, `OP_WRITE`, `OP_START`, `OP_ABORT`)
  - response codes (`0x80` base, `0xFE`, `0xFF`)
  - error codes
  - state encoding
- The executor shares the 40-bit word layout constants from the same package.
- A single module; no sub-module is needed.

## Test plan
- SET_ADDR `0x1234`, then WRITE N=2 with words `0x4000000005` and `0x8100000001` → writes at `0x1234` and `0x1235`, each with a single-cycle `wr`. Responses `0x81`, `0x82`.
- SET_ADDR `0xFFFF`, WRITE N=2 → addresses `0xFFFF`, then `0x0000`.
- WRITE N=0 followed by 1280 bytes → exactly 256 writes, response after the last write.
- START `0x0010` → one-cycle `start`, `start_addr`=`0x0010`, response `0x83`. ABORT → one `abort` pulse, response `0x84`.
- Opcode `0x55` → response `0xFF`, `last_error`=1, no strobes. A good SET_ADDR afterwards clears `last_error` to 0.
- TIMEOUT_CYCLES=100: WRITE N=1 with 3 data bytes, then idle → at cycle 100 response `0xFE`, `last_error`=3, no write. Holding `out_ready`=0 keeps `in_ready`=0.
